// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router control path: state encoding,
// address width and the reserved drop address.
package router_pkg;

  localparam int ST_W   = 4;
  localparam int ADDR_W = 2;

  // Packets addressed here are consumed without being written anywhere.
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

  // Unlisted encodings of the 4-bit register are recovered to DA by the FSM.
  typedef enum logic [ST_W-1:0] {
    DA   = 4'd0,  // decode address (idle / header wait)
    LFD  = 4'd1,  // load first data (header byte)
    LD   = 4'd2,  // load payload data
    FFS  = 4'd3,  // FIFO full stall
    LAF  = 4'd4,  // load after full
    LP   = 4'd5,  // load parity byte
    CPE  = 4'd6,  // check parity error
    WTE  = 4'd7,  // wait till destination FIFO empty
    DROP = 4'd8   // discard packet with invalid address
  } state_e;

endpackage

// File: rtl/router_fsm.sv
// Control FSM for the 1x3 router: decodes the destination, sequences the
// header/payload/parity capture in router_reg, strobes the FIFO write and
// discards packets sent to an invalid address.
module router_fsm
  import router_pkg::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [ADDR_W-1:0]    addr_q,
  output logic                 drop_active
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_d;

  logic din_valid;   // incoming header address names an existing port
  logic din_empty;   // FIFO of the incoming header address is empty
  logic din_drop;    // incoming header must be discarded
  logic q_empty;     // FIFO of the latched address is empty
  logic q_soft_rst;  // soft reset of the latched port

  // Per-port selection by the incoming and the latched address.
  always_comb begin
    // NOTE: every signal gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    din_valid  = 1'b0;
    din_empty  = 1'b0;
    q_empty    = 1'b0;
    q_soft_rst = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (data_in == ADDR_W'(i)) begin
        din_valid = 1'b1;
        din_empty = fifo_empty[i];
      end
      if (addr_q == ADDR_W'(i)) begin
        q_empty    = fifo_empty[i];
        q_soft_rst = soft_reset[i];
      end
    end
    din_drop = !din_valid || (data_in == ADDR_INVALID);
  end

  // Next-state and next-address logic; soft reset of the active port wins.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (state_q == DA && pkt_valid) begin
      addr_d = data_in;
    end
    if (q_soft_rst) begin
      state_d = DA;
    end else begin
      unique case (state_q)
        DA: begin
          if (pkt_valid) begin
            if (din_drop)       state_d = DROP;
            else if (din_empty) state_d = LFD;
            else                state_d = WTE;
          end
        end
        WTE:  if (q_empty) state_d = LFD;
        LFD:  state_d = LD;
        LD: begin
          if (fifo_full)       state_d = FFS;
          else if (!pkt_valid) state_d = LP;
        end
        FFS:  if (!fifo_full) state_d = LAF;
        LAF: begin
          if (parity_done)        state_d = DA;
          else if (low_pkt_valid) state_d = LP;
          else                    state_d = LD;
        end
        LP:   state_d = CPE;
        CPE:  state_d = fifo_full ? FFS : DA;
        DROP: if (!pkt_valid) state_d = DA;
        default: state_d = DA;
      endcase
    end
  end

  // State and address registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed by the combinational blocks.
    if (reset) begin
      state_q <= DA;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Moore outputs decoded straight from the state register.
  assign detect_add    = (state_q == DA);
  assign lfd_state     = (state_q == LFD);
  assign ld_state      = (state_q == LD);
  assign laf_state     = (state_q == LAF);
  assign full_state    = (state_q == FFS);
  assign rst_int_reg   = (state_q == CPE);
  assign drop_active   = (state_q == DROP);
  assign write_enb_reg = lfd_state | ld_state | laf_state | (state_q == LP);
  assign busy          = !((state_q == DA) || (state_q == LD));

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios plus randomized inputs,
// every cycle compared against a packet-level behavioural model.
module tb_router_fsm;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pkt_valid = 1'b0;
  logic [1:0] data_in = '0;
  logic       fifo_full = 1'b0;
  logic [2:0] fifo_empty = 3'b111;
  logic [2:0] soft_reset = '0;
  logic       parity_done = 1'b0;
  logic       low_pkt_valid = 1'b0;

  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy, drop_active;
  logic [1:0] addr_q;

  always #5 clock = ~clock;

  router_fsm #(.NUM_PORTS(3)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .addr_q(addr_q),
    .drop_active(drop_active)
  );

  // Packet-level phases of the model, named after what the router is doing.
  typedef enum {P_HDR, P_WAIT, P_FIRST, P_BODY, P_STALL, P_RESUME,
                P_PARITY, P_CHECK, P_DISCARD} phase_t;

  phase_t ph = P_HDR;
  int     m_addr = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  int     t_we, t_full, t_drop, t_rst, t_wait;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    int     a;
    phase_t nx;
    if (reset) begin
      ph = P_HDR;
      m_addr = 0;
      return;
    end
    nx = ph;
    a  = int'(data_in);
    case (ph)
      P_HDR:
        if (pkt_valid) begin
          if (a >= 3)             nx = P_DISCARD;
          else if (fifo_empty[a]) nx = P_FIRST;
          else                    nx = P_WAIT;
        end
      P_WAIT:    if (fifo_empty[m_addr]) nx = P_FIRST;
      P_FIRST:   nx = P_BODY;
      P_BODY:    nx = fifo_full ? P_STALL : (pkt_valid ? P_BODY : P_PARITY);
      P_STALL:   if (!fifo_full) nx = P_RESUME;
      P_RESUME:  nx = parity_done ? P_HDR : (low_pkt_valid ? P_PARITY : P_BODY);
      P_PARITY:  nx = P_CHECK;
      P_CHECK:   nx = fifo_full ? P_STALL : P_HDR;
      P_DISCARD: if (!pkt_valid) nx = P_HDR;
      default:   nx = P_HDR;
    endcase
    if (m_addr < 3 && soft_reset[m_addr]) nx = P_HDR;
    if (ph == P_HDR && pkt_valid) m_addr = a;
    ph = nx;
  endtask

  // Compare every DUT output with what the current model phase implies.
  task automatic compare_all();
    logic writing;
    writing = (ph == P_FIRST || ph == P_BODY || ph == P_RESUME || ph == P_PARITY);
    check("detect_add",    8'(detect_add),    8'(ph == P_HDR));
    check("lfd_state",     8'(lfd_state),     8'(ph == P_FIRST));
    check("ld_state",      8'(ld_state),      8'(ph == P_BODY));
    check("laf_state",     8'(laf_state),     8'(ph == P_RESUME));
    check("full_state",    8'(full_state),    8'(ph == P_STALL));
    check("rst_int_reg",   8'(rst_int_reg),   8'(ph == P_CHECK));
    check("drop_active",   8'(drop_active),   8'(ph == P_DISCARD));
    check("write_enb_reg", 8'(write_enb_reg), 8'(writing));
    check("busy",          8'(busy),          8'(!(ph == P_HDR || ph == P_BODY)));
    check("addr_q",        8'(addr_q),        8'(m_addr));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      compare_all();
      t_we   += int'(write_enb_reg);
      t_full += int'(full_state);
      t_drop += int'(drop_active);
      t_rst  += int'(rst_int_reg);
      t_wait += int'(busy && !write_enb_reg && !full_state && !rst_int_reg && !drop_active);
    end
  endtask

  task automatic clear_tallies();
    t_we = 0; t_full = 0; t_drop = 0; t_rst = 0; t_wait = 0;
  endtask

  initial begin
    clear_tallies();

    // Reset for two cycles.
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    check("reset_detect_add", 8'(detect_add), 8'd1);
    check("reset_busy",       8'(busy),       8'd0);
    check("reset_we",         8'(write_enb_reg), 8'd0);
    check("reset_addr",       8'(addr_q),     8'd0);

    // Header 8'h39 (addr 1), 14 payload bytes, then parity.
    clear_tallies();
    pkt_valid = 1'b1; data_in = 2'b01;
    run(15);
    pkt_valid = 1'b0; data_in = 2'b10;
    run(3);
    check("pkt_writes",     8'(t_we),       8'd16);
    check("pkt_rst_int",    8'(t_rst),      8'd1);
    check("pkt_back_to_da", 8'(detect_add), 8'd1);
    check("pkt_addr",       8'(addr_q),     8'd1);

    // Same packet with a 3-cycle FIFO-full stall after payload byte 5.
    clear_tallies();
    pkt_valid = 1'b1; data_in = 2'b01;
    run(6);
    fifo_full = 1'b1;
    run(3);
    check("stall_cycles", 8'(t_full), 8'd3);
    check("stall_no_we",  8'(t_we),   8'd6);
    fifo_full = 1'b0;
    run(1);
    check("laf_after_full", 8'(laf_state), 8'd1);
    check("laf_busy",       8'(busy),      8'd1);
    run(1);
    check("ld_after_laf", 8'(ld_state), 8'd1);
    // fifo_full and !pkt_valid together in LD: the stall wins.
    fifo_full = 1'b1; pkt_valid = 1'b0;
    run(1);
    check("full_beats_parity", 8'(full_state), 8'd1);
    fifo_full = 1'b0; low_pkt_valid = 1'b1;
    run(4);
    low_pkt_valid = 1'b0;
    check("stall_pkt_done", 8'(detect_add), 8'd1);

    // Address 2 waits while its FIFO is not empty.
    clear_tallies();
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b011;
    run(4);
    check("wte_cycles", 8'(t_wait), 8'd4);
    fifo_empty = 3'b111;
    run(1);
    check("wte_to_lfd", 8'(lfd_state), 8'd1);
    pkt_valid = 1'b0;
    run(4);
    check("zero_len_done", 8'(detect_add), 8'd1);

    // Address 3 is discarded for as long as pkt_valid stays high.
    clear_tallies();
    pkt_valid = 1'b1; data_in = ADDR_INVALID;
    run(6);
    pkt_valid = 1'b0;
    run(1);
    check("drop_cycles",  8'(t_drop),     8'd6);
    check("drop_no_we",   8'(t_we),       8'd0);
    check("drop_release", 8'(detect_add), 8'd1);

    // Soft reset: other port ignored, own port returns to DA.
    pkt_valid = 1'b1; data_in = 2'b01;
    run(3);
    soft_reset = 3'b001;
    run(1);
    check("soft_other_ignored", 8'(ld_state), 8'd1);
    soft_reset = 3'b010; pkt_valid = 1'b0;
    run(1);
    check("soft_own_to_da", 8'(detect_add), 8'd1);
    soft_reset = 3'b000;
    run(1);

    // Randomized inputs with occasional reset, checked every cycle.
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(63) == 0);
      pkt_valid     = ($urandom_range(3) != 0);
      data_in       = 2'($urandom);
      fifo_full     = ($urandom_range(3) == 0);
      fifo_empty    = 3'($urandom);
      soft_reset    = ($urandom_range(15) == 0) ? 3'($urandom) : 3'b000;
      parity_done   = ($urandom_range(3) == 0);
      low_pkt_valid = ($urandom_range(3) == 0);
      run(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
